// File: rtl/cpu_job_host_if.sv
// Handshake and memory-port bundle between the job host and its surroundings.
// The slave modport is the host's view; the master modport is the view of
// whatever drives start/streams and models the core and memory.
interface cpu_job_host_if #(
    parameter int AW = 8
);
    // job control
    logic          start;
    logic          busy;
    logic          job_done;
    logic          timeout_err;
    // preload stream
    logic          ld_valid;
    logic [7:0]    ld_data;
    logic          ld_ready;
    // core control
    logic          core_reset;
    logic          core_req;
    logic          core_done;
    // data-memory host port and mux select
    logic          mem_sel;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    // result stream
    logic          res_valid;
    logic [7:0]    res_data;
    logic          res_ready;

    modport slave (
        input  start, ld_valid, ld_data, core_done, mem_rdata, res_ready,
        output busy, job_done, timeout_err, ld_ready, core_reset, core_req,
               mem_sel, mem_we, mem_addr, mem_wdata, res_valid, res_data
    );

    modport master (
        output start, ld_valid, ld_data, core_done, mem_rdata, res_ready,
        input  busy, job_done, timeout_err, ld_ready, core_reset, core_req,
               mem_sel, mem_we, mem_addr, mem_wdata, res_valid, res_data
    );
endinterface

// File: rtl/cpu_job_host.sv
// Host-side job initiator: preloads operands into the core's data memory
// while the core is held in reset, releases the core and pulses core_req,
// waits for core_done under a cycle timeout, then streams result bytes out.
module cpu_job_host #(
    parameter int AW          = 8,
    parameter int LOAD_BASE   = 0,
    parameter int LOAD_LEN    = 64,
    parameter int RESULT_BASE = 64,
    parameter int RESULT_LEN  = 16,
    parameter int TIMEOUT     = 4096
) (
    input  logic             clk,
    input  logic             reset,
    cpu_job_host_if.slave    bus
);
    // Beat counter is shared by preload and unload; it only needs to reach
    // the larger length minus one.
    localparam int MAX_LEN = (LOAD_LEN > RESULT_LEN) ? LOAD_LEN : RESULT_LEN;
    localparam int CNT_W   = (MAX_LEN < 2) ? 1 : $clog2(MAX_LEN);
    localparam int TW      = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] LOAD_LAST   = CNT_W'((LOAD_LEN > 0) ? LOAD_LEN - 1 : 0);
    localparam logic [CNT_W-1:0] RESULT_LAST = CNT_W'((RESULT_LEN > 0) ? RESULT_LEN - 1 : 0);
    localparam logic [TW-1:0]    RUN_LAST    = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]    RUN_SAT     = TW'(TIMEOUT);
    localparam logic [AW-1:0]    LOAD_BASE_A = AW'(LOAD_BASE);
    localparam logic [AW-1:0]    RES_BASE_A  = AW'(RESULT_BASE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_UNLOAD,
        S_FINISH
    } state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [TW-1:0]    run_cnt_reg;
    logic             fetch_reg;      // mem_rdata holds the byte for cnt_reg this cycle
    logic             res_valid_reg;
    logic [7:0]       res_data_reg;
    logic             timeout_err_reg;

    logic [AW-1:0]    load_addr;
    logic [AW-1:0]    res_addr;

    // Job sequencing: state, beat/cycle counters, result register and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            cnt_reg         <= '0;
            run_cnt_reg     <= '0;
            fetch_reg       <= 1'b0;
            res_valid_reg   <= 1'b0;
            res_data_reg    <= 8'h00;
            timeout_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        timeout_err_reg <= 1'b0;
                        cnt_reg         <= '0;
                        run_cnt_reg     <= '0;
                        state_reg       <= (LOAD_LEN == 0) ? S_RUN : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (bus.ld_valid) begin
                        if (cnt_reg == LOAD_LAST) begin
                            cnt_reg     <= '0;
                            run_cnt_reg <= '0;
                            state_reg   <= S_RUN;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (run_cnt_reg != RUN_SAT) begin
                        run_cnt_reg <= run_cnt_reg + 1'b1;
                    end
                    // completion wins over a timeout detected in the same cycle
                    if (bus.core_done) begin
                        cnt_reg       <= '0;
                        fetch_reg     <= 1'b0;
                        res_valid_reg <= 1'b0;
                        state_reg     <= (RESULT_LEN == 0) ? S_FINISH : S_UNLOAD;
                    end else if (run_cnt_reg == RUN_LAST) begin
                        timeout_err_reg <= 1'b1;
                        state_reg       <= S_FINISH;
                    end
                end
                S_UNLOAD: begin
                    if (res_valid_reg) begin
                        // the next address was already presented while waiting
                        // for acceptance, so its data arrives next cycle
                        if (bus.res_ready) begin
                            res_valid_reg <= 1'b0;
                            if (cnt_reg == RESULT_LAST) begin
                                state_reg <= S_FINISH;
                            end else begin
                                cnt_reg   <= cnt_reg + 1'b1;
                                fetch_reg <= 1'b1;
                            end
                        end
                    end else if (fetch_reg) begin
                        res_data_reg  <= bus.mem_rdata;
                        res_valid_reg <= 1'b1;
                        fetch_reg     <= 1'b0;
                    end else begin
                        fetch_reg <= 1'b1;
                    end
                end
                S_FINISH: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    // Address generation; both bases wrap modulo 2^AW. During unload the
    // address runs one ahead while a byte is on offer to overlap the read.
    assign load_addr = LOAD_BASE_A + AW'(cnt_reg);
    assign res_addr  = RES_BASE_A + AW'(cnt_reg) + AW'(res_valid_reg);

    assign bus.ld_ready    = (state_reg == S_LOAD);
    assign bus.core_reset  = (state_reg != S_RUN);
    assign bus.mem_sel     = (state_reg != S_RUN);
    assign bus.core_req    = (state_reg == S_RUN) && (run_cnt_reg == '0);
    assign bus.mem_we      = (state_reg == S_LOAD) && bus.ld_valid;
    assign bus.mem_addr    = (state_reg == S_LOAD) ? load_addr : res_addr;
    assign bus.mem_wdata   = bus.ld_data;
    assign bus.res_valid   = res_valid_reg;
    assign bus.res_data    = res_data_reg;
    assign bus.busy        = (state_reg != S_IDLE);
    assign bus.job_done    = (state_reg == S_FINISH);
    assign bus.timeout_err = timeout_err_reg;

endmodule

// File: tb/tb_cpu_job_host.sv
// Randomized bench for cpu_job_host: three differently parameterized hosts,
// each with a small core model and data memory, checked cycle by cycle
// against a phase-level reference model of the job protocol.
module tb_cpu_job_host;
    localparam int N = 3;
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_UNLOAD = 3, P_FIN = 4;

    // Per-instance parameters: 0 nominal, 1 no-load/timeout/wrap, 2 load-wrap/no-result
    function automatic int p_lb(input int i); return (i == 2) ? 250 : 0; endfunction
    function automatic int p_ll(input int i); return (i == 0) ? 4 : (i == 1) ? 0 : 10; endfunction
    function automatic int p_rb(input int i); return (i == 0) ? 64 : (i == 1) ? 254 : 0; endfunction
    function automatic int p_rl(input int i); return (i == 0) ? 16 : (i == 1) ? 4 : 0; endfunction
    function automatic int p_to(input int i); return (i == 0) ? 4096 : (i == 1) ? 8 : 16; endfunction
    function automatic int p_wb(input int i); return (i == 0) ? 64 : (i == 1) ? 254 : 100; endfunction

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start[N], ld_valid[N], res_ready[N], core_done[N];
    logic [7:0] ld_data[N], mem_rdata[N];
    logic       ld_ready[N], core_reset[N], core_req[N], mem_sel[N], mem_we[N];
    logic       res_valid[N], busy[N], job_done[N], timeout_err[N];
    logic [7:0] mem_addr[N], mem_wdata[N], res_data[N];

    logic [7:0]  mem[N][256];
    logic [15:0] run_k[N];
    int          done_at[N];
    logic        mem_init;
    logic [7:0]  mem_seed;

    logic [7:0]  exp_mem[N][256];
    logic        exp_to[N];
    int          n_checks = 0;
    int          n_fail = 0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            cpu_job_host_if #(.AW(8)) bus ();
            assign bus.start     = start[gi];
            assign bus.ld_valid  = ld_valid[gi];
            assign bus.ld_data   = ld_data[gi];
            assign bus.core_done = core_done[gi];
            assign bus.mem_rdata = mem_rdata[gi];
            assign bus.res_ready = res_ready[gi];
            assign ld_ready[gi]    = bus.ld_ready;
            assign core_reset[gi]  = bus.core_reset;
            assign core_req[gi]    = bus.core_req;
            assign mem_sel[gi]     = bus.mem_sel;
            assign mem_we[gi]      = bus.mem_we;
            assign mem_addr[gi]    = bus.mem_addr;
            assign mem_wdata[gi]   = bus.mem_wdata;
            assign res_valid[gi]   = bus.res_valid;
            assign res_data[gi]    = bus.res_data;
            assign busy[gi]        = bus.busy;
            assign job_done[gi]    = bus.job_done;
            assign timeout_err[gi] = bus.timeout_err;

            cpu_job_host #(
                .AW(8), .LOAD_BASE(p_lb(gi)), .LOAD_LEN(p_ll(gi)),
                .RESULT_BASE(p_rb(gi)), .RESULT_LEN(p_rl(gi)), .TIMEOUT(p_to(gi))
            ) u_dut (
                .clk   (clk),
                .reset (reset),
                .bus   (bus)
            );
        end
    endgenerate

    function automatic logic [7:0] init_byte(input int i, input int a);
        return 8'(a * 37 + i * 11) ^ mem_seed;
    endfunction

    // Core model: done after a chosen number of RUN cycles
    always_comb begin
        for (int i = 0; i < N; i++) begin
            core_done[i] = !core_reset[i] && (int'(run_k[i]) == done_at[i]);
        end
    end

    // Memory with host/core mux; the core always tries to store, even in reset
    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (mem_init) begin
                for (int a = 0; a < 256; a++) mem[i][a] <= init_byte(i, a);
            end else if (mem_sel[i]) begin
                if (mem_we[i]) mem[i][mem_addr[i]] <= mem_wdata[i];
            end else begin
                mem[i][8'(p_wb(i) + int'(run_k[i]))] <= core_reset[i] ? 8'hEE : 8'h80 + run_k[i][7:0];
            end
            mem_rdata[i] <= mem[i][mem_sel[i] ? mem_addr[i] : 8'(p_wb(i) + int'(run_k[i]))];
            run_k[i]     <= core_reset[i] ? 16'd0 : run_k[i] + 16'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input int i);
        check_eq("rst_core_reset", core_reset[i], 1);
        check_eq("rst_mem_sel", mem_sel[i], 1);
        check_eq("rst_core_req", core_req[i], 0);
        check_eq("rst_mem_we", mem_we[i], 0);
        check_eq("rst_ld_ready", ld_ready[i], 0);
        check_eq("rst_res_valid", res_valid[i], 0);
        check_eq("rst_res_data", res_data[i], 0);
        check_eq("rst_busy", busy[i], 0);
        check_eq("rst_job_done", job_done[i], 0);
        check_eq("rst_timeout_err", timeout_err[i], 0);
    endtask

    task automatic check_mem_image(input int i);
        int bad = 0;
        for (int a = 0; a < 256; a++) if (mem[i][a] !== exp_mem[i][a]) bad++;
        check_eq("mem_image_bad_bytes", bad, 0);
    endtask

    // One job on instance i; abort_beats >= 0 resets the block mid-unload
    task automatic run_job(input int i, input int ld_pct, input int rd_pct,
                           input int done_k, input bit fixed_data, input int abort_beats);
        int ph, ld_cnt, run_cyc, ul_cnt, ul_wait, cyc, a, n_res;
        bit aborted;
        logic [7:0] exp_res[$];
        ld_cnt = 0; run_cyc = 0; ul_cnt = 0; ul_wait = 0; cyc = 0; n_res = 0; aborted = 0;
        done_at[i] = done_k;

        @(negedge clk);
        start[i] = 1'b1; ld_valid[i] = 1'b0; res_ready[i] = 1'b0;
        #1;
        check_eq("start_busy", busy[i], 0);
        check_eq("start_timeout_err", timeout_err[i], exp_to[i]);
        exp_to[i] = 1'b0;
        ph = (p_ll(i) == 0) ? P_RUN : P_LOAD;

        while (ph != P_IDLE) begin
            @(negedge clk);
            if (abort_beats >= 0 && ph == P_UNLOAD && ul_cnt == abort_beats) begin
                aborted = 1;
                break;
            end
            start[i]     = (ph == P_FIN) ? 1'b0 : 1'($urandom_range(0, 1));
            ld_valid[i]  = ($urandom_range(0, 99) < ld_pct);
            ld_data[i]   = fixed_data ? 8'(8'h11 * (ld_cnt + 1)) : 8'($urandom);
            res_ready[i] = ($urandom_range(0, 99) < rd_pct);
            #1;
            check_eq("ld_ready", ld_ready[i], ph == P_LOAD);
            check_eq("core_reset", core_reset[i], ph != P_RUN);
            check_eq("mem_sel", mem_sel[i], ph != P_RUN);
            check_eq("core_req", core_req[i], ph == P_RUN && run_cyc == 0);
            check_eq("busy", busy[i], 1);
            check_eq("job_done", job_done[i], ph == P_FIN);
            check_eq("timeout_err", timeout_err[i], exp_to[i]);
            check_eq("mem_we", mem_we[i], ph == P_LOAD && ld_valid[i]);
            check_eq("res_valid", res_valid[i], ph == P_UNLOAD && ul_wait == 0);
            case (ph)
                P_LOAD: begin
                    if (ld_valid[i]) begin
                        a = (p_lb(i) + ld_cnt) % 256;
                        check_eq("ld_addr", mem_addr[i], a);
                        check_eq("ld_wdata", mem_wdata[i], ld_data[i]);
                        exp_mem[i][a] = ld_data[i];
                        ld_cnt++;
                        if (ld_cnt == p_ll(i)) ph = P_RUN;
                    end
                end
                P_RUN: begin
                    exp_mem[i][(p_wb(i) + run_cyc) % 256] = 8'(8'h80 + run_cyc);
                    if (run_cyc == done_k) begin
                        if (p_rl(i) == 0) begin
                            ph = P_FIN;
                        end else begin
                            ph = P_UNLOAD; ul_cnt = 0; ul_wait = 2;
                            exp_res = {};
                            for (int j = 0; j < p_rl(i); j++)
                                exp_res.push_back(exp_mem[i][(p_rb(i) + j) % 256]);
                        end
                    end else if (run_cyc == p_to(i) - 1) begin
                        exp_to[i] = 1'b1;
                        ph = P_FIN;
                    end
                    run_cyc++;
                end
                P_UNLOAD: begin
                    if (ul_wait > 0) begin
                        ul_wait--;
                    end else begin
                        check_eq("res_data", res_data[i], exp_res[ul_cnt]);
                        if (res_ready[i]) begin
                            ul_cnt++; n_res++;
                            if (ul_cnt == p_rl(i)) ph = P_FIN;
                            else ul_wait = 1;
                        end
                    end
                end
                default: ph = P_IDLE;
            endcase
            cyc++;
            if (cyc > 20000) begin
                check_eq("cycle_budget", cyc, 0);
                break;
            end
        end

        if (aborted) begin
            reset = 1'b1; start[i] = 1'b0; ld_valid[i] = 1'b0; res_ready[i] = 1'b0;
            @(negedge clk);
            #1;
            check_reset_vals(i);
            reset = 1'b0;
            for (int k = 0; k < N; k++) exp_to[k] = 1'b0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                #1;
                check_eq("abort_job_done", job_done[i], 0);
                check_eq("abort_busy", busy[i], 0);
            end
        end else begin
            @(negedge clk);
            #1;
            check_eq("end_busy", busy[i], 0);
            check_eq("end_job_done", job_done[i], 0);
        end
        check_mem_image(i);
        $display("job inst=%0d done_k=%0d run_cycles=%0d results=%0d timeout=%0d aborted=%0d",
                 i, done_k, run_cyc, n_res, exp_to[i], aborted);
    endtask

    initial begin
        mem_seed = 8'($urandom);
        reset = 1'b1; mem_init = 1'b1;
        for (int i = 0; i < N; i++) begin
            start[i] = 0; ld_valid[i] = 0; res_ready[i] = 0; ld_data[i] = 0;
            done_at[i] = 1000; exp_to[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) check_reset_vals(i);
        reset = 1'b0; mem_init = 1'b0;
        for (int i = 0; i < N; i++)
            for (int a = 0; a < 256; a++) exp_mem[i][a] = init_byte(i, a);
        @(negedge clk);
        #1;
        for (int i = 0; i < N; i++) check_reset_vals(i);

        run_job(0, 100, 100, 10, 1, -1);          // nominal
        run_job(0, 30, 30, 10, 1, -1);            // backpressure
        for (int r = 0; r < 3; r++)
            run_job(0, $urandom_range(20, 100), $urandom_range(20, 100),
                    $urandom_range(0, 20), 0, -1);
        run_job(1, 100, 100, 1000, 0, -1);        // timeout, no load
        run_job(1, 50, 50, 2, 0, -1);             // clears error, result wrap
        run_job(1, 100, 100, 7, 0, -1);           // done on the last allowed cycle
        run_job(2, 100, 100, 3, 0, -1);           // load wrap, no results
        run_job(2, 40, 100, 0, 0, -1);
        run_job(0, 100, 100, 5, 1, 3);            // reset mid-unload
        run_job(0, 70, 70, 4, 1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
